// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a synchronous clear, used both for tracking
// the addresses of in-flight fetches and for buffering returned instructions.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic             push_en;
   logic             pop_en;

   assign pop_en   = pop && !empty;
   assign push_en  = push && (!full || pop_en);
   assign full     = (count_q == DEPTH_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem[rd_ptr];

   // Storage array; contents need no reset because empty masks the head.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and fill level; clear wins over any push or pop that cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_en && !pop_en) begin
            count_q <= count_q + 1'b1;
         end else if (pop_en && !push_en) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues word fetches under a
// credit limit, pairs returned words with their addresses and hands them to
// decode. A redirect restarts fetch and turns everything older into garbage,
// whether buffered or still in flight.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        id_ready_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(BUF_DEPTH);

   fetch_state_e     state_q;
   fetch_state_e     state_d;
   logic [31:0]      pc_q;
   logic [CNT_W-1:0] outstanding_q;
   logic [CNT_W-1:0] outstanding_d;
   logic [CNT_W-1:0] discard_q;
   logic [CNT_W-1:0] discard_d;
   logic [CNT_W:0]   credit_used;

   logic             grant;
   logic             rsp_accept;
   logic             buf_pop;

   logic [31:0]      rsp_pc;
   logic             addr_full;
   logic             addr_empty;
   logic [CNT_W-1:0] addr_count;

   fetch_entry_t     buf_push_entry;
   fetch_entry_t     buf_head;
   logic             buf_full;
   logic             buf_empty;
   logic [CNT_W-1:0] occupancy;

   assign credit_used    = {1'b0, outstanding_q} + {1'b0, occupancy};
   assign grant          = imem_req_o && imem_gnt_i;
   assign rsp_accept     = imem_rvalid_i && (discard_q == '0) && !redirect_i && !addr_empty;
   assign buf_pop        = !buf_empty && id_ready_i && !redirect_i;
   assign buf_push_entry = '{pc: rsp_pc, instr: imem_rdata_i};

   assign imem_addr_o = pc_q;
   assign if_valid_o  = !buf_empty;
   assign if_instr_o  = if_valid_o ? buf_head.instr : 32'h0;
   assign if_pc_o     = if_valid_o ? buf_head.pc    : 32'h0;

   // Addresses of live requests, oldest first, so each response finds its PC.
   fetch_fifo #(
      .WIDTH (32),
      .DEPTH (BUF_DEPTH)
   ) u_addr_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (redirect_i),
      .push      (grant && !redirect_i),
      .push_data (pc_q),
      .pop       (rsp_accept),
      .pop_data  (rsp_pc),
      .full      (addr_full),
      .empty     (addr_empty),
      .count     (addr_count)
   );

   // Returned instructions waiting for decode, paired with their PCs.
   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (BUF_DEPTH)
   ) u_instr_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (redirect_i),
      .push      (rsp_accept),
      .push_data (buf_push_entry),
      .pop       (buf_pop),
      .pop_data  (buf_head),
      .full      (buf_full),
      .empty     (buf_empty),
      .count     (occupancy)
   );

   // State register: IDLE only lasts for the first edge after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and request: ask only while every possible response is
   // guaranteed a free buffer slot (the full flags are a redundant guard).
   always_comb begin
      state_d    = state_q;
      imem_req_o = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = RUN;
         end
         RUN: begin
            imem_req_o = (credit_used < CREDIT_MAX) && !addr_full && !buf_full;
         end
      endcase
   end

   // Counter updates. Every response retires one outstanding request, stale
   // or not. On redirect, all live requests (the ones still tracked in the
   // address FIFO) become stale alongside those already stale, plus any
   // request granted now, minus a response arriving now.
   always_comb begin
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
      discard_d     = discard_q;
      if (redirect_i) begin
         discard_d = discard_q + addr_count + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
      end else if (imem_rvalid_i && (discard_q != '0)) begin
         discard_d = discard_q - 1'b1;
      end
   end

   // Outstanding and discard registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   // Program counter: held while a request waits for its grant, stepped on
   // grant, and reloaded (word aligned) on redirect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= RESET_PC;
      end else if (redirect_i) begin
         pc_q <= {redirect_pc_i[31:2], 2'b00};
      end else if (grant) begin
         pc_q <= pc_q + INSTR_BYTES;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a latency-programmable memory, a queue-based
// reference model compared every cycle, and directed scenarios with
// hand-derived literal expectations.
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 4;
   localparam logic [31:0] MAGIC     = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        id_ready_i = 1'b0;
   logic        if_valid_o;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   logic        gnt_knob = 1'b1;
   logic        ready_knob = 1'b1;
   logic        redirect_knob = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   int          mem_lat = 1;

   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];

   logic        running = 1'b0;
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_infl_addr[$];
   logic        m_infl_stale[$];
   logic [31:0] m_buf_pc[$];

   fetch_ctrl #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .id_ready_i    (id_ready_i),
      .if_valid_o    (if_valid_o),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Outputs the model says the DUT must show in the current cycle.
   task automatic compare_model();
      logic exp_req;
      exp_req = running && ((m_infl_addr.size() + m_buf_pc.size()) < BUF_DEPTH);
      check_output("model_req", {31'b0, imem_req_o}, {31'b0, exp_req});
      check_output("model_addr", imem_addr_o, m_pc);
      check_output("model_valid", {31'b0, if_valid_o}, {31'b0, (m_buf_pc.size() != 0)});
      if (m_buf_pc.size() != 0) begin
         check_output("model_pc", if_pc_o, m_buf_pc[0]);
         check_output("model_instr", if_instr_o, m_buf_pc[0] ^ MAGIC);
      end
   endtask

   // One clock cycle: compare at the falling edge, drive inputs, advance the
   // memory and the model across the rising edge, return at the next fall.
   task automatic apply_stimulus();
      logic        m_req;
      logic        m_grant;
      logic        m_pop;
      logic        m_push;
      logic        rsp_stale;
      logic [31:0] rsp_addr;
      logic        mem_grant;
      logic [31:0] mem_grant_addr;
      compare_model();
      imem_gnt_i    = gnt_knob;
      id_ready_i    = ready_knob;
      redirect_i    = redirect_knob;
      redirect_pc_i = redirect_target;
      if (mem_due_q.size() != 0 && mem_due_q[0] <= cycle) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_addr_q[0] ^ MAGIC;
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = 32'hDEAD_BEEF;
      end
      mem_grant      = imem_req_o && imem_gnt_i;
      mem_grant_addr = imem_addr_o;
      m_req   = running && ((m_infl_addr.size() + m_buf_pc.size()) < BUF_DEPTH);
      m_grant = m_req && gnt_knob;
      m_pop   = (m_buf_pc.size() != 0) && ready_knob && !redirect_knob;
      @(posedge clk);
      if (imem_rvalid_i) begin
         void'(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end
      if (mem_grant) begin
         mem_addr_q.push_back(mem_grant_addr);
         mem_due_q.push_back(cycle + mem_lat);
      end
      m_push   = 1'b0;
      rsp_addr = 32'h0;
      if (imem_rvalid_i && m_infl_addr.size() != 0) begin
         rsp_addr  = m_infl_addr.pop_front();
         rsp_stale = m_infl_stale.pop_front();
         m_push    = !rsp_stale && !redirect_knob;
      end
      if (redirect_knob) begin
         m_buf_pc.delete();
         foreach (m_infl_stale[i]) m_infl_stale[i] = 1'b1;
      end else begin
         if (m_pop) void'(m_buf_pc.pop_front());
         if (m_push) m_buf_pc.push_back(rsp_addr);
      end
      if (m_grant) begin
         m_infl_addr.push_back(m_pc);
         m_infl_stale.push_back(redirect_knob);
      end
      if (redirect_knob) begin
         m_pc = {redirect_target[31:2], 2'b00};
      end else if (m_grant) begin
         m_pc = m_pc + 32'd4;
      end
      running = 1'b1;
      cycle++;
      @(negedge clk);
   endtask

   task automatic run_to(input int target);
      while (cycle < target) apply_stimulus();
   endtask

   task automatic check_reset_values();
      check_output("rst_req", {31'b0, imem_req_o}, 32'd0);
      check_output("rst_addr", imem_addr_o, RESET_PC);
      check_output("rst_valid", {31'b0, if_valid_o}, 32'd0);
      check_output("rst_instr", if_instr_o, 32'h0);
      check_output("rst_pc", if_pc_o, 32'h0);
   endtask

   // Hold reset for two cycles, clear the environment, release on a fall.
   task automatic apply_reset();
      reset_n         = 1'b0;
      imem_gnt_i      = 1'b0;
      imem_rvalid_i   = 1'b0;
      redirect_i      = 1'b0;
      id_ready_i      = 1'b0;
      gnt_knob        = 1'b1;
      ready_knob      = 1'b1;
      redirect_knob   = 1'b0;
      mem_lat         = 1;
      mem_addr_q.delete();
      mem_due_q.delete();
      m_infl_addr.delete();
      m_infl_stale.delete();
      m_buf_pc.delete();
      m_pc    = RESET_PC;
      running = 1'b0;
      cycle   = 0;
      repeat (2) @(negedge clk);
      check_reset_values();
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset and a steady stream, one instruction per cycle from cycle 3.
      apply_reset();
      run_to(1);
      check_output("stream_req_c1", {31'b0, imem_req_o}, 32'd1);
      check_output("stream_addr_c1", imem_addr_o, 32'h0000_0000);
      run_to(3);
      check_output("stream_valid_c3", {31'b0, if_valid_o}, 32'd1);
      check_output("stream_pc_c3", if_pc_o, 32'h0000_0000);
      check_output("stream_instr_c3", if_instr_o, 32'hA5A5_A5A5);
      for (int i = 1; i < 6; i++) begin
         run_to(3 + i);
         check_output("stream_valid", {31'b0, if_valid_o}, 32'd1);
         check_output("stream_pc", if_pc_o, 32'(4 * i));
      end

      // Backpressure: four grants, then hold; resume with no gaps.
      apply_reset();
      ready_knob = 1'b0;
      run_to(5);
      check_output("bp_req_stop", {31'b0, imem_req_o}, 32'd0);
      run_to(10);
      check_output("bp_req_held", {31'b0, imem_req_o}, 32'd0);
      check_output("bp_head", if_pc_o, 32'h0000_0000);
      ready_knob = 1'b1;
      for (int i = 1; i < 8; i++) begin
         run_to(10 + i);
         check_output("bp_valid", {31'b0, if_valid_o}, 32'd1);
         check_output("bp_pc", if_pc_o, 32'(4 * i));
      end

      // Redirect with two requests in flight at memory latency 3.
      apply_reset();
      mem_lat = 3;
      run_to(2);
      redirect_knob   = 1'b1;
      redirect_target = 32'h0000_1002;
      run_to(3);
      redirect_knob = 1'b0;
      check_output("rd3_addr", imem_addr_o, 32'h0000_1000);
      for (int c = 3; c < 7; c++) begin
         run_to(c);
         check_output("rd3_valid_low", {31'b0, if_valid_o}, 32'd0);
      end
      run_to(7);
      check_output("rd3_pc", if_pc_o, 32'h0000_1000);
      check_output("rd3_instr", if_instr_o, 32'h0000_1000 ^ MAGIC);
      run_to(8);
      check_output("rd3_pc_next", if_pc_o, 32'h0000_1004);

      // Redirect coinciding with a grant, an rvalid and a pop.
      apply_reset();
      run_to(5);
      check_output("sim_valid_c5", {31'b0, if_valid_o}, 32'd1);
      check_output("sim_pc_c5", if_pc_o, 32'h0000_0008);
      redirect_knob   = 1'b1;
      redirect_target = 32'h0000_2000;
      run_to(6);
      redirect_knob = 1'b0;
      check_output("sim_valid_c6", {31'b0, if_valid_o}, 32'd0);
      check_output("sim_addr_c6", imem_addr_o, 32'h0000_2000);
      run_to(7);
      check_output("sim_valid_c7", {31'b0, if_valid_o}, 32'd0);
      run_to(8);
      check_output("sim_pc_c8", if_pc_o, 32'h0000_2000);

      // Wrap-around of the PC past the top of the address space.
      redirect_knob   = 1'b1;
      redirect_target = 32'hFFFF_FFF8;
      run_to(9);
      redirect_knob = 1'b0;
      check_output("wrap_valid_c9", {31'b0, if_valid_o}, 32'd0);
      run_to(11);
      check_output("wrap_pc0", if_pc_o, 32'hFFFF_FFF8);
      run_to(12);
      check_output("wrap_pc1", if_pc_o, 32'hFFFF_FFFC);
      run_to(13);
      check_output("wrap_pc2", if_pc_o, 32'h0000_0000);
      gnt_knob = 1'b0;
      run_to(16);
      gnt_knob = 1'b1;
      run_to(22);

      // Reset in the middle of operation with three instructions buffered.
      apply_reset();
      ready_knob = 1'b0;
      run_to(5);
      check_output("mid_valid_pre", {31'b0, if_valid_o}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_values();
      apply_reset();
      run_to(1);
      check_output("mid_refetch_addr", imem_addr_o, RESET_PC);
      run_to(3);
      check_output("mid_refetch_pc", if_pc_o, RESET_PC);
      run_to(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
